// File: rtl/countdown_timer.sv
// BCD countdown timer: loads a clamped MM:SS:FF preset, decrements it on each
// frame tick while running, and raises an alarm when it reaches zero.
// One debounced push-button drives start / pause / acknowledge.
module countdown_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       btn_origin,
  input  logic       load,
  input  logic [3:0] pre_frm0,
  input  logic [3:0] pre_frm1,
  input  logic [3:0] pre_sec0,
  input  logic [3:0] pre_sec1,
  input  logic [3:0] pre_min0,
  input  logic [3:0] pre_min1,
  output logic [3:0] small_sec0,
  output logic [3:0] small_sec1,
  output logic [3:0] sec0,
  output logic [3:0] sec1,
  output logic [3:0] min0,
  output logic [3:0] min1,
  output logic       running,
  output logic       alarm,
  output logic       done_pulse
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Six BCD digits packed low to high: frm0, frm1, sec0, sec1, min0, min1.
  // Even positions are units digits (limit 9), odd positions tens (limit 5).

  // Clamp every digit of a raw preset to its field limit.
  function automatic logic [23:0] clamp_preset(input logic [23:0] raw);
    logic [23:0] res;
    logic [3:0]  lim;
    logic [3:0]  dig;
    res = 24'd0;
    for (int i = 0; i < 6; i++) begin
      lim = (i % 2 == 1) ? 4'd5 : 4'd9;
      dig = raw[i*4 +: 4];
      if (dig > lim) begin
        res[i*4 +: 4] = lim;
      end else begin
        res[i*4 +: 4] = dig;
      end
    end
    return res;
  endfunction

  // Subtract one frame with a borrow rippling from frm0 up to min1.
  function automatic logic [23:0] bcd_decrement(input logic [23:0] val);
    logic [23:0] res;
    logic [3:0]  lim;
    logic [3:0]  dig;
    logic        borrow;
    res    = val;
    borrow = 1'b1;
    for (int i = 0; i < 6; i++) begin
      lim = (i % 2 == 1) ? 4'd5 : 4'd9;
      dig = val[i*4 +: 4];
      if (borrow) begin
        if (dig == 4'd0) begin
          res[i*4 +: 4] = lim;
          borrow        = 1'b1;
        end else begin
          res[i*4 +: 4] = dig - 4'd1;
          borrow        = 1'b0;
        end
      end else begin
        res[i*4 +: 4] = dig;
      end
    end
    return res;
  endfunction

  state_t      r_state;
  state_t      w_state_next;
  logic        r_btn_delay;
  logic [23:0] r_digits;
  logic [23:0] r_preset;
  logic [23:0] w_digits_next;
  logic [23:0] w_preset_next;
  logic        r_running;
  logic        r_alarm;
  logic        r_done_pulse;

  logic        w_press;
  logic [23:0] w_preset_raw;
  logic [23:0] w_preset_clamped;
  logic [23:0] w_digits_dec;
  logic        w_digits_zero;
  logic        w_dec_zero;

  assign w_press          = btn_origin & ~r_btn_delay;
  assign w_preset_raw     = {pre_min1, pre_min0, pre_sec1, pre_sec0, pre_frm1, pre_frm0};
  assign w_preset_clamped = clamp_preset(w_preset_raw);
  assign w_digits_dec     = bcd_decrement(r_digits);
  assign w_digits_zero    = (r_digits == 24'd0);
  assign w_dec_zero       = (w_digits_dec == 24'd0);

  // Next-state, next-digit and next-preset decode for the control FSM.
  always_comb begin
    w_state_next  = r_state;
    w_digits_next = r_digits;
    w_preset_next = r_preset;
    case (r_state)
      ST_IDLE: begin
        if (load) begin
          // A load wins over a simultaneous press.
          w_preset_next = w_preset_clamped;
          w_digits_next = w_preset_clamped;
          w_state_next  = ST_IDLE;
        end else if (w_press && !w_digits_zero) begin
          w_state_next = ST_RUN;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (tick) begin
          if (w_digits_zero) begin
            // Zero is never decremented; treat it as expired.
            w_state_next = ST_DONE;
          end else begin
            w_digits_next = w_digits_dec;
            if (w_dec_zero) begin
              w_state_next = ST_DONE;
            end else if (w_press) begin
              w_state_next = ST_PAUSE;
            end else begin
              w_state_next = ST_RUN;
            end
          end
        end else if (w_press) begin
          w_state_next = ST_PAUSE;
        end else begin
          w_state_next = ST_RUN;
        end
      end
      ST_PAUSE: begin
        if (load) begin
          w_preset_next = w_preset_clamped;
          w_digits_next = w_preset_clamped;
          w_state_next  = ST_IDLE;
        end else if (w_press) begin
          w_state_next = ST_RUN;
        end else begin
          w_state_next = ST_PAUSE;
        end
      end
      ST_DONE: begin
        if (w_press) begin
          // Acknowledge restores the last preset for another run.
          w_digits_next = r_preset;
          w_state_next  = ST_IDLE;
        end else begin
          w_state_next = ST_DONE;
        end
      end
      default: begin
        w_state_next  = ST_IDLE;
        w_digits_next = r_digits;
        w_preset_next = r_preset;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Delayed button level for rising-edge press detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_btn_delay <= 1'b0;
    end else begin
      r_btn_delay <= btn_origin;
    end
  end

  // Remaining-time digits and stored preset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_digits <= 24'd0;
      r_preset <= 24'd0;
    end else begin
      r_digits <= w_digits_next;
      r_preset <= w_preset_next;
    end
  end

  // Registered status flags decoded from the state being entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_running    <= 1'b0;
      r_alarm      <= 1'b0;
      r_done_pulse <= 1'b0;
    end else begin
      r_running    <= (w_state_next == ST_RUN);
      r_alarm      <= (w_state_next == ST_DONE);
      r_done_pulse <= (w_state_next == ST_DONE) && (r_state != ST_DONE);
    end
  end

  assign small_sec0 = r_digits[3:0];
  assign small_sec1 = r_digits[7:4];
  assign sec0       = r_digits[11:8];
  assign sec1       = r_digits[15:12];
  assign min0       = r_digits[19:16];
  assign min1       = r_digits[23:20];
  assign running    = r_running;
  assign alarm      = r_alarm;
  assign done_pulse = r_done_pulse;

endmodule

// File: doc/countdown_timer.md
# countdown_timer

BCD countdown timer that pairs with the up-counting stopwatch: it loads a preset of minutes, seconds and sub-second frames and decrements it to zero at the tick rate. It raises an alarm on expiry. Start/pause/acknowledge come from one push-button, edge-detected internally. It sits beside the stopwatch in the display datapath and drives the same six seven-segment digit positions.

## Interface
- No parameters; field limits are fixed (low digit 0-9, high digit 0-5 for every field).
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- tick  in  1  one-cycle count-enable pulse at the frame rate
- btn_origin  in  1  raw start/pause/ack button level, already debounced
- load  in  1  capture preset inputs (level, sampled each cycle)
- pre_frm0, pre_frm1, pre_sec0, pre_sec1, pre_min0, pre_min1  in  4 each  preset BCD digits
- small_sec0, small_sec1, sec0, sec1, min0, min1  out  4 each  current remaining-time BCD digits
- running  out  1  high while in RUN
- alarm  out  1  high while in DONE
- done_pulse  out  1  one-cycle pulse on the edge entering DONE

## Operation
- Press detect: btn_delay <= btn_origin on clk; press = btn_origin & ~btn_delay.
- Preset register (6 digits) holds the last loaded value. Loaded digits above a field limit are clamped to that limit; for example, pre_sec1=7 stores 5.
- FSM states are IDLE, RUN, PAUSE and DONE:
  - IDLE: load copies the clamped preset to both the preset register and the digits. A press with nonzero digits goes to RUN. A press with all-zero digits stays in IDLE.
  - RUN: a tick decrements the digits. A press goes to PAUSE. If the decrement makes the value 00:00:00, the FSM goes to DONE.
  - PAUSE: the digits are frozen. A press goes to RUN. load behaves as in IDLE and the FSM goes to IDLE.
  - DONE: the digits hold at zero. A press reloads the digits from the preset register and goes to IDLE.
- load is ignored in RUN and DONE.
- Decrement is a borrow chain frm0 -> frm1 -> sec0 -> sec1 -> min0 -> min1. A digit at 0 that receives a borrow wraps to its limit (9 or 5) and passes the borrow on.
- Zero is never decremented; DONE is entered instead.

## Timing
- Reset (rst=0, asynchronous) sets all digits to 0, the preset register to 0, btn_delay to 0, state to IDLE, and running, alarm and done_pulse to 0.
- Press to state change takes 1 clk: the state updates on the edge where press is high.
- Tick to digit update takes 1 clk, only when the current state is RUN.
- Tick and press in the same RUN cycle: the decrement happens and the state goes to PAUSE (or to DONE if the value reaches zero; DONE wins over PAUSE).
- load and press in the same IDLE or PAUSE cycle: the load is applied, the press is ignored, and the state is IDLE.
- running and alarm are registered and decoded from the state, so they reflect the new state 1 clk after the causing edge inputs.
- done_pulse is high for exactly the first cycle the state is DONE.
- Reset mid-RUN clears everything immediately. Counting does not resume after rst returns to 1.
- Holding btn_origin high gives a single press.

## Test plan
- Reset checks: with rst=0 all outputs are 0 and the state is IDLE. Release rst, then apply tick pulses → digits stay 00:00:00 and running=0.
- Load and run: load 00:01:05, press → running=1. After 5 ticks the display is 00:01:00. One more tick → 00:00:59.
- Borrow chain: load 10:00:00, press, one tick → 09:59:59.
- Clamping: load min1=9, sec1=8, frm0=12 → stored 59:59:59.
- Pause and resume: during RUN, press → PAUSE; 3 ticks → no change. Press again → RUN, and the next tick decrements.
- Expiry: load 00:00:02, press, 2 ticks → 00:00:00, alarm=1, done_pulse high for 1 cycle. Further ticks → no change. Press → IDLE with digits back at 00:00:02.
- Edge cases:
  - Press with zero digits in IDLE → stays IDLE.
  - Tick and press in the same RUN cycle → decrement and PAUSE.
  - load during RUN → ignored.
  - rst asserted mid-RUN → all outputs 0 asynchronously.
